adder_tree_arbiter: RTL and testbench

Shares one pipelined adder_tree instance between NUM_REQ requesters, each presenting a full NUM_INPUTS-sample vector. A round-robin arbiter issues at most one vector per cycle into the tree. A tag FIFO tracks the requester ID of each in-flight vector and returns every sum, labelled with that ID. Sits between the per-channel sample producers and the shared adder tree in the BPM processing chain.

---
 rtl/adder_tree_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adder_tree_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_arbiter.sv
// Round-robin front end that shares one pipelined adder tree between NUM_REQ vector producers.
// A tag FIFO pairs each returning sum with the ID of the requester that issued it.
module adder_tree_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_INPUTS   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int TREE_LATENCY = 4,
  parameter int DEPTH        = $clog2(NUM_INPUTS),
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int TAG_DEPTH    = 2**$clog2(TREE_LATENCY+2)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         enable_mask,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic                                       tree_valid_in,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]           tree_data_in,
  input  logic                                       tree_valid_out,
  input  logic signed [DATA_WIDTH+DEPTH-1:0]         tree_data_out,
  output logic                                       res_valid,
  output logic [ID_W-1:0]                            res_id,
  output logic signed [DATA_WIDTH+DEPTH-1:0]         res_data,
  output logic                                       tag_err
);

  localparam int VEC_W  = NUM_INPUTS*DATA_WIDTH;
  localparam int SUM_W  = DATA_WIDTH+DEPTH;
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int CNT_W  = TAG_AW+1;

  // ---------------- arbitration ----------------
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_vec;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               fifo_stall;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  assign eligible   = req_valid & enable_mask;
  assign fifo_stall = (cnt_reg >= CNT_W'(TAG_DEPTH-1));

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && eligible[ID_W'(cand)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(cand);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any && !fifo_stall) grant_vec[grant_id] = 1'b1;
  end

  assign req_ready = grant_vec;
  assign xfer      = |(grant_vec & req_valid);
  assign ptr_next  = xfer ? grant_id : ptr_reg;

  // ---------------- granted vector select ----------------
  logic [VEC_W-1:0] masked_vec [NUM_REQ];
  logic [VEC_W-1:0] granted_vec;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign masked_vec[gi] = req_data[gi*VEC_W +: VEC_W] & {VEC_W{grant_vec[gi]}};
  end

  always_comb begin
    granted_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) granted_vec = granted_vec | masked_vec[i];
  end

  // ---------------- tag FIFO (first-word-fall-through) ----------------
  logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic              fifo_empty;
  logic              push, pop;
  logic [ID_W-1:0]   head_id;

  assign fifo_empty = (cnt_reg == '0);
  assign push       = xfer;
  assign pop        = tree_valid_out & ~fifo_empty;
  assign head_id    = tag_mem[rd_ptr_reg];

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CNT_W'(1);
      2'b01:   cnt_next = cnt_reg - CNT_W'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= grant_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      ptr_reg    <= ID_W'(NUM_REQ-1);
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + TAG_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + TAG_AW'(1);
      cnt_reg <= cnt_next;
      ptr_reg <= ptr_next;
    end
  end

  // ---------------- issue and result stages ----------------
  logic                    tree_valid_in_reg;
  logic [VEC_W-1:0]        tree_data_in_reg;
  logic                    res_valid_reg;
  logic [ID_W-1:0]         res_id_reg;
  logic signed [SUM_W-1:0] res_data_reg;
  logic                    tag_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_valid_in_reg <= 1'b0;
      tree_data_in_reg  <= '0;
    end else begin
      tree_valid_in_reg <= xfer;
      if (xfer) tree_data_in_reg <= granted_vec;
    end
  end

  // A sum arriving with no outstanding tag is dropped and flagged until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_data_reg  <= '0;
      tag_err_reg   <= 1'b0;
    end else begin
      res_valid_reg <= pop;
      if (pop) begin
        res_id_reg   <= head_id;
        res_data_reg <= tree_data_out;
      end
      if (tree_valid_out && fifo_empty) tag_err_reg <= 1'b1;
    end
  end

  assign tree_valid_in = tree_valid_in_reg;
  assign tree_data_in  = tree_data_in_reg;
  assign res_valid     = res_valid_reg;
  assign res_id        = res_id_reg;
  assign res_data      = res_data_reg;
  assign tag_err       = tag_err_reg;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Self-checking bench for adder_tree_arbiter: models the attached adder tree, a transaction-level
// scoreboard of grants and results, directed vector tables and randomized traffic.
module tb_adder_tree_arbiter;

  localparam int NR    = 4;
  localparam int NI    = 10;
  localparam int DW    = 16;
  localparam int L     = 4;
  localparam int DEPTH = $clog2(NI);
  localparam int SW    = DW + DEPTH;
  localparam int VW    = NI * DW;
  localparam int IDW   = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     enable_mask;
  logic [NR-1:0]     req_valid;
  logic [NR*VW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              tree_valid_in;
  logic [VW-1:0]     tree_data_in;
  logic              tree_valid_out;
  logic signed [SW-1:0] tree_data_out;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic signed [SW-1:0] res_data;
  logic              tag_err;
  logic              tree_inject;

  adder_tree_arbiter #(
    .NUM_REQ(NR), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .TREE_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .enable_mask(enable_mask), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .tree_valid_in(tree_valid_in),
    .tree_data_in(tree_data_in), .tree_valid_out(tree_valid_out),
    .tree_data_out(tree_data_out), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  function automatic longint vec_sum(input logic [VW-1:0] v);
    longint s;
    logic [DW-1:0] smp;
    s = 0;
    for (int j = 0; j < NI; j++) begin
      smp = v[j*DW +: DW];
      s += longint'($signed(smp));
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input int v);
    logic [VW-1:0] r;
    logic [DW-1:0] s;
    s = DW'(v);
    for (int j = 0; j < NI; j++) r[j*DW +: DW] = s;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int j = 0; j < NI; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int id, input logic [VW-1:0] v);
    req_data[id*VW +: VW] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // ---------------- adder tree model: fixed-latency pipeline of sums ----------------
  logic [L-1:0]          tv_pipe;
  logic signed [SW-1:0]  td_pipe [L];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_pipe <= '0;
    end else begin
      tv_pipe    <= {tv_pipe[L-2:0], tree_valid_in};
      td_pipe[0] <= SW'(vec_sum(tree_data_in));
      for (int k = 1; k < L; k++) td_pipe[k] <= td_pipe[k-1];
    end
  end

  assign tree_valid_out = tv_pipe[L-1] | tree_inject;
  assign tree_data_out  = tv_pipe[L-1] ? td_pipe[L-1] : SW'(12345);

  // ---------------- transaction-level reference and scoreboard ----------------
  typedef struct {
    int     id;
    longint sum;
    int     due;
  } res_t;

  res_t          res_q[$];
  int            m_ptr;
  logic          exp_tvi;
  logic [VW-1:0] exp_tdi;
  longint        exp_id;
  longint        exp_data;
  logic          exp_err;
  logic [NR-1:0] m_grant;

  always @(negedge clk) begin : monitor
    logic [NR-1:0] elig;
    int            gid;
    int            c;
    res_t          r;
    if (rst) begin
      res_q.delete();
      m_ptr    = NR - 1;
      exp_tvi  = 1'b0;
      exp_tdi  = '0;
      exp_id   = 0;
      exp_data = 0;
      exp_err  = 1'b0;
      m_grant  = '0;
    end else begin
      chk("tree_valid_in", longint'(tree_valid_in), longint'(exp_tvi));
      chk_vec("tree_data_in", tree_data_in, exp_tdi);
      chk("tag_err", longint'(tag_err), longint'(exp_err));
      if (res_q.size() > 0 && res_q[0].due == cyc) begin
        chk("res_valid", longint'(res_valid), 1);
        r        = res_q.pop_front();
        exp_id   = r.id;
        exp_data = r.sum;
      end else begin
        chk("res_valid", longint'(res_valid), 0);
      end
      chk("res_id", longint'(res_id), exp_id);
      chk("res_data", longint'(res_data), exp_data);

      elig = req_valid & enable_mask;
      gid  = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (m_ptr + k) % NR;
        if (gid < 0 && elig[c]) gid = c;
      end
      m_grant = (gid >= 0) ? (NR'(1) << gid) : '0;
      chk("req_ready", longint'(req_ready), longint'(m_grant));

      if (tree_inject && res_q.size() == 0) exp_err = 1'b1;
      exp_tvi = (gid >= 0);
      if (gid >= 0) begin
        m_ptr   = gid;
        exp_tdi = req_data[gid*VW +: VW];
        res_q.push_back('{gid, vec_sum(exp_tdi), cyc + 2 + L});
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int     id;
    int     sample;
    longint sum;
  } vec_t;

  vec_t          tbl[5];
  int            rot[3];
  logic [NR-1:0] pend;

  initial begin
    tbl[0] = '{2, 1, 10};
    tbl[1] = '{0, -32768, -327680};
    tbl[2] = '{1, 32767, 327670};
    tbl[3] = '{2, -7, -70};
    tbl[4] = '{3, 123, 1230};
    rot[0] = 0; rot[1] = 1; rot[2] = 3;

    rst         = 1'b1;
    enable_mask = '1;
    req_valid   = '0;
    req_data    = '0;
    tree_inject = 1'b0;

    @(negedge clk); #1;
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_tree_valid_in", longint'(tree_valid_in), 0);
    chk("rst_tag_err", longint'(tag_err), 0);
    chk("rst_res_data", longint'(res_data), 0);
    step();
    rst = 1'b0;
    idle(2);

    // single-vector issues, latency and signed extremes
    foreach (tbl[t]) begin
      step();
      set_vec(tbl[t].id, fill_vec(tbl[t].sample));
      req_valid = NR'(1) << tbl[t].id;
      @(negedge clk); #1;
      chk("tbl_ready", longint'(req_ready), longint'(NR'(1) << tbl[t].id));
      for (int k = 1; k <= L + 3; k++) begin
        step();
        if (k == 1) req_valid = '0;
        @(negedge clk); #1;
        chk("tbl_tree_valid_in", longint'(tree_valid_in), longint'(k == 1));
        chk("tbl_res_valid", longint'(res_valid), longint'(k == L + 2));
        if (k == L + 2) begin
          chk("tbl_res_id", longint'(res_id), tbl[t].id);
          chk("tbl_res_data", longint'(res_data), tbl[t].sum);
        end
      end
    end

    // all four requesters, full-throughput rotation
    step();
    for (int i = 0; i < NR; i++) set_vec(i, fill_vec(i + 1));
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("rr_grant", longint'(req_ready), longint'(NR'(1) << (c % NR)));
      step();
    end
    req_valid = '0;
    idle(L + 4);

    // masked requester 2, then re-enabled mid-stream
    enable_mask = 4'b1011;
    req_valid   = '1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      chk("mask_no_req2", longint'(req_ready[2]), 0);
      chk("mask_grant", longint'(req_ready), longint'(NR'(1) << rot[c % 3]));
      step();
    end
    enable_mask = '1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("unmask_grant", longint'(req_ready), longint'(NR'(1) << c));
      step();
    end
    req_valid = '0;
    idle(L + 4);

    // spurious tree output with nothing in flight
    tree_inject = 1'b1;
    step();
    tree_inject = 1'b0;
    @(negedge clk); #1;
    chk("tag_err_set", longint'(tag_err), 1);
    chk("tag_err_no_res", longint'(res_valid), 0);
    idle(5);
    @(negedge clk); #1;
    chk("tag_err_sticky", longint'(tag_err), 1);

    // randomized traffic with random masks
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      step();
      pend = pend & ~m_grant;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          set_vec(i, rand_vec());
        end
      end
      req_valid = pend;
      if (c % 20 == 0) begin
        if ($urandom_range(0, 1) == 0) enable_mask = '1;
        else enable_mask = NR'($urandom_range(0, (1 << NR) - 1));
      end
    end

    // reset with vectors in flight
    step();
    enable_mask = '1;
    pend        = '1;
    req_valid   = '1;
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", longint'(res_valid), 0);
    chk("arst_tree_valid_in", longint'(tree_valid_in), 0);
    chk_vec("arst_tree_data_in", tree_data_in, '0);
    chk("arst_res_id", longint'(res_id), 0);
    chk("arst_res_data", longint'(res_data), 0);
    chk("arst_tag_err", longint'(tag_err), 0);
    idle(2);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("arst_first_grant", longint'(req_ready), 1);
    step();
    req_valid = '0;
    idle(L + 6);
    chk("drain_empty", longint'(res_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
